register_file_sb: RTL



---
 rtl/vcpu32_rf_pkg.sv | 17 +
 rtl/rf_write_arbiter.sv | 38 +++
 rtl/register_file_sb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vcpu32_rf_pkg.sv
// Shared types and constants for the VCPU-32 register file.
// Clear-sequencer state, default geometry and address-width helper.
package vcpu32_rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_NUM_REGS = 16;
    localparam int RF_DATA_W   = 32;

    function automatic int rf_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// Per-register write-port arbitration for the register file.
// Lowest-index enabled port targeting a register wins that register.
module rf_write_arbiter
    import vcpu32_rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_WR   = 2,
    localparam int AW      = rf_aw(NUM_REGS)
) (
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*AW-1:0]       wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0]        reg_we,
    output logic [NUM_REGS*DATA_W-1:0] reg_wdata
);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic              we_r;
        logic [DATA_W-1:0] wd_r;

        // Scan from the highest index down so the lowest match lands last
        always_comb begin
            we_r = 1'b0;
            wd_r = '0;
            for (int w = NUM_WR - 1; w >= 0; w--) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
                    we_r = 1'b1;
                    wd_r = wr_data[w*DATA_W +: DATA_W];
                end
            end
        end

        assign reg_we[r]                    = we_r;
        assign reg_wdata[r*DATA_W +: DATA_W] = wd_r;
    end

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with write priority, bypass and scoreboard.
// Storage is zeroed by a one-entry-per-cycle clear sequencer.
module register_file_sb
    import vcpu32_rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0,
    localparam int AW      = rf_aw(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*AW-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*AW-1:0]       wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       rsv_en,
    input  logic [AW-1:0]              rsv_addr,
    input  logic                       clr_req,
    output logic                       busy,
    output logic [NUM_REGS-1:0]        pending
);

    localparam logic [NUM_REGS-1:0] R0_MASK =
        (ZERO_R0 != 0) ? NUM_REGS'(1) : '0;

    rf_state_t             state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [DATA_W-1:0]     mem_q [NUM_REGS];

    logic [NUM_REGS-1:0]        arb_we;
    logic [NUM_REGS*DATA_W-1:0] arb_wdata;
    logic [NUM_REGS-1:0]        eff_we;
    logic                       wr_open;
    logic                       rsv_ok;

    rf_write_arbiter #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .NUM_WR   (NUM_WR)
    ) u_arb (
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .reg_we    (arb_we),
        .reg_wdata (arb_wdata)
    );

    // A clear request in IDLE drops the writes of that same cycle
    always_comb begin
        wr_open = (state_q == RF_IDLE) && !clr_req;
        eff_we  = arb_we & ~R0_MASK & {NUM_REGS{wr_open}};
        rsv_ok  = rsv_en && wr_open &&
                  !((ZERO_R0 != 0) && (rsv_addr == '0));
    end

    // Clear sequencer next state: walk every entry, then return to IDLE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            RF_CLEAR: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(NUM_REGS - 1)) begin
                    state_d = RF_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
        endcase
    end

    // Scoreboard: writes retire, reserve wins over a same-cycle write
    always_comb begin
        pending_d = pending_q & ~eff_we;
        if (rsv_ok) begin
            pending_d[rsv_addr] = 1'b1;
        end
        if ((state_q == RF_CLEAR) || clr_req) begin
            pending_d = '0;
        end
    end

    // Control state with asynchronous reset into a fresh clear sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            idx_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    // Storage has no reset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (state_q == RF_CLEAR) begin
            mem_q[idx_q] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (eff_we[r]) begin
                    mem_q[r] <= arb_wdata[r*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] d;
        logic              v;

        assign a = rd_addr[p*AW +: AW];

        // Read mux: clear blanks, r0 tie-off, bypass, then storage
        always_comb begin
            d = '0;
            v = 1'b0;
            if (state_q == RF_CLEAR) begin
                d = '0;
                v = 1'b0;
            end else if ((ZERO_R0 != 0) && (a == '0)) begin
                d = '0;
                v = 1'b1;
            end else if ((BYPASS != 0) && eff_we[a]) begin
                d = arb_wdata[int'(a)*DATA_W +: DATA_W];
                v = 1'b1;
            end else begin
                d = mem_q[a];
                v = !pending_q[a];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = d;
        assign rd_valid[p]                 = v;
    end

    assign busy    = (state_q == RF_CLEAR);
    assign pending = pending_q;

endmodule
